// File: rtl/cordic_fp_pkg.sv
// Shared IEEE-754 single-precision definitions for the CORDIC operand path.
// Provides field widths, the exponent bias, the operand class enum and
// small field-extraction helpers used by the float-to-fixed converter.
package cordic_fp_pkg;

  localparam int FP_EXP_W = 8;
  localparam int FP_MAN_W = 23;
  localparam int FP_BIAS  = 127;

  typedef enum logic [2:0] {ZERO, DENORM, NORMAL, INF, NAN} fp_class_t;

  function automatic logic fp_sign(input logic [31:0] f);
    return f[31];
  endfunction

  function automatic logic [FP_EXP_W-1:0] fp_exp(input logic [31:0] f);
    return f[30:23];
  endfunction

  function automatic logic [FP_MAN_W-1:0] fp_frac(input logic [31:0] f);
    return f[22:0];
  endfunction

  // 24-bit significand; the hidden bit is only present for normal numbers
  function automatic logic [FP_MAN_W:0] fp_mant(input logic [31:0] f);
    return {(fp_exp(f) != '0), fp_frac(f)};
  endfunction

  function automatic fp_class_t fp_classify(input logic [31:0] f);
    if (fp_exp(f) == '0)
      return (fp_frac(f) == '0) ? ZERO : DENORM;
    else if (fp_exp(f) == '1)
      return (fp_frac(f) == '0) ? INF : NAN;
    else
      return NORMAL;
  endfunction

endpackage

// File: rtl/fx_align_shifter.sv
// Combinational bidirectional barrel shifter for the float-to-fixed path.
// A non-negative shift moves the significand left; a negative shift moves it
// right. The magnitude is MAG_W bits; if any set bit would land above it the
// magnitude is forced to all ones so the saturation stage always catches it.
// Macro ROUND_NEAREST_EN: when defined, the guard and sticky bits of a right
// shift are produced as extra outputs; otherwise they are absent.
// Ports:
//   mant   in  24     significand with hidden bit
//   shift  in  10     signed shift amount (left when >= 0)
//   mag    out MAG_W  aligned magnitude (integer part of the fixed value)
//   guard  out 1      first bit shifted out (ROUND_NEAREST_EN only)
//   sticky out 1      OR of all lower bits shifted out (ROUND_NEAREST_EN only)
module fx_align_shifter #(
  parameter int MAG_W = 33
) (
  input  logic [23:0]        mant,
  input  logic signed [9:0]  shift,
`ifdef ROUND_NEAREST_EN
  output logic               guard,
  output logic               sticky,
`endif
  output logic [MAG_W-1:0]   mag
);

  localparam int WW = MAG_W + 24;

  logic [WW-1:0] wide;
  logic [9:0]    amt;
`ifdef ROUND_NEAREST_EN
  logic [49:0]   ext;
`endif

  always_comb begin
    wide = '0;
    amt  = '0;
`ifdef ROUND_NEAREST_EN
    ext    = '0;
    guard  = 1'b0;
    sticky = 1'b0;
`endif
    if (!shift[9]) begin
      amt = shift;
      // Any left shift of MAG_W or more pushes the leading one out of range
      if (amt >= 10'(MAG_W))
        wide = '1;
      else
        wide = {{MAG_W{1'b0}}, mant} << amt;
    end else begin
      amt = 10'(-shift);
`ifdef ROUND_NEAREST_EN
      // Beyond 25 places the whole significand is below the guard position
      if (amt >= 10'd26) begin
        sticky = |mant;
      end else begin
        ext    = {mant, 26'b0} >> amt;
        wide   = {{MAG_W{1'b0}}, ext[49:26]};
        guard  = ext[25];
        sticky = |ext[24:0];
      end
`else
      wide = {{MAG_W{1'b0}}, 24'(mant >> amt)};
`endif
    end
    mag = (|wide[WW-1:MAG_W]) ? '1 : wide[MAG_W-1:0];
  end

endmodule

// File: rtl/float_to_fixed_pipe.sv
// Pipelined, handshaked IEEE-754 single to signed fixed-point converter.
// Three stages: decode, align shift, round/negate/saturate. Each stage has
// its own valid and advances when the stage after it can take the word, so
// the pipe runs at one word per cycle and holds its contents under stall.
// Macro ROUND_NEAREST_EN: when defined, the last stage rounds to nearest
// (ties to even) using guard/sticky; otherwise the magnitude is truncated.
// Ports:
//   clk        in  1      clock, rising edge
//   reset_n    in  1      synchronous active-low reset
//   in_valid   in  1      input word valid
//   in_ready   out 1      converter accepts input this cycle
//   in_data    in  32     IEEE-754 single
//   out_valid  out 1      result valid
//   out_ready  in  1      downstream accepts result
//   out_data   out OUT_W  two's complement result, FRAC_BITS fraction bits
//   out_ovf    out 1      result saturated (too large or infinite)
//   out_unf    out 1      nonzero finite input produced 0
//   out_nan    out 1      input was NaN
module float_to_fixed_pipe
  import cordic_fp_pkg::*;
#(
  parameter int OUT_W     = 32,
  parameter int FRAC_BITS = 30
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_ovf,
  output logic             out_unf,
  output logic             out_nan
);

  localparam int MAG_W = OUT_W + 1;
  // fixed = mant * 2^(exp - bias - 23 + FRAC_BITS)
  localparam logic signed [9:0] SH_OFS = 10'(FRAC_BITS - FP_BIAS - FP_MAN_W);
  localparam logic [OUT_W-1:0] MAX_V   = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W-1:0] MIN_V   = {1'b1, {(OUT_W-1){1'b0}}};
  localparam logic [MAG_W:0]   NEG_LIM = {3'b001, {(OUT_W-1){1'b0}}};

`ifdef ROUND_NEAREST_EN
  function automatic logic [MAG_W:0] round_mag(input logic [MAG_W-1:0] m,
                                               input logic g, input logic s);
    return {1'b0, m} + (MAG_W+1)'(g & (s | m[0]));
  endfunction
`else
  function automatic logic [MAG_W:0] round_mag(input logic [MAG_W-1:0] m);
    return {1'b0, m};
  endfunction
`endif

  // Returns {ovf, value}; -2^(OUT_W-1) is representable, +2^(OUT_W-1) is not
  function automatic logic [OUT_W:0] saturate(input logic sign, input logic [MAG_W:0] m);
    logic signed [OUT_W-1:0] v;
    v = $signed(m[OUT_W-1:0]);
    if (!sign)
      return (m >= NEG_LIM) ? {1'b1, MAX_V} : {1'b0, v};
    else
      return (m > NEG_LIM) ? {1'b1, MIN_V} : {1'b0, OUT_W'(-v)};
  endfunction

  logic vld_p0, vld_p1, vld_p2;
  logic rdy_p0, rdy_p1, rdy_p2;

  assign rdy_p2    = !vld_p2 || out_ready;
  assign rdy_p1    = !vld_p1 || rdy_p2;
  assign rdy_p0    = !vld_p0 || rdy_p1;
  assign in_ready  = rdy_p0;
  assign out_valid = vld_p2;

  // ---- S1: decode ----
  logic            sign_p0;
  logic [7:0]      exp_p0;
  logic [23:0]     mant_p0;
  fp_class_t       cls_p0;

  always_ff @(posedge clk) begin
    if (!reset_n)    vld_p0 <= 1'b0;
    else if (rdy_p0) vld_p0 <= in_valid;
  end

  always_ff @(posedge clk) begin
    if (rdy_p0 && in_valid) begin
      sign_p0 <= fp_sign(in_data);
      exp_p0  <= fp_exp(in_data);
      mant_p0 <= fp_mant(in_data);
      cls_p0  <= fp_classify(in_data);
    end
  end

  // ---- S2: align shift ----
  logic signed [9:0] shift_c;
  logic [MAG_W-1:0]  mag_c;
  logic              sign_p1;
  fp_class_t         cls_p1;
  logic [MAG_W-1:0]  mag_p1;
`ifdef ROUND_NEAREST_EN
  logic              guard_c, sticky_c, guard_p1, sticky_p1;
`endif

  assign shift_c = $signed({2'b00, exp_p0}) + SH_OFS;

  fx_align_shifter #(.MAG_W(MAG_W)) u_shift (
    .mant   (mant_p0),
    .shift  (shift_c),
`ifdef ROUND_NEAREST_EN
    .guard  (guard_c),
    .sticky (sticky_c),
`endif
    .mag    (mag_c)
  );

  always_ff @(posedge clk) begin
    if (!reset_n)    vld_p1 <= 1'b0;
    else if (rdy_p1) vld_p1 <= vld_p0;
  end

  always_ff @(posedge clk) begin
    if (rdy_p1 && vld_p0) begin
      sign_p1 <= sign_p0;
      cls_p1  <= cls_p0;
      mag_p1  <= mag_c;
`ifdef ROUND_NEAREST_EN
      guard_p1  <= guard_c;
      sticky_p1 <= sticky_c;
`endif
    end
  end

  // ---- S3: round / negate / saturate ----
  logic [MAG_W:0]          rmag_c;
  logic [OUT_W:0]          sat_c;
  logic signed [OUT_W-1:0] res_c;
  logic                    ovf_c, unf_c, nan_c;

  always_comb begin
    rmag_c = '0;
    sat_c  = '0;
    res_c  = '0;
    ovf_c  = 1'b0;
    unf_c  = 1'b0;
    nan_c  = 1'b0;
    case (cls_p1)
      ZERO:   ;
      DENORM: unf_c = 1'b1;
      INF: begin
        ovf_c = 1'b1;
        res_c = sign_p1 ? MIN_V : MAX_V;
      end
      NAN:    nan_c = 1'b1;
      default: begin
`ifdef ROUND_NEAREST_EN
        rmag_c = round_mag(mag_p1, guard_p1, sticky_p1);
`else
        rmag_c = round_mag(mag_p1);
`endif
        sat_c = saturate(sign_p1, rmag_c);
        res_c = sat_c[OUT_W-1:0];
        ovf_c = sat_c[OUT_W];
        unf_c = (rmag_c == '0);
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      vld_p2   <= 1'b0;
      out_data <= '0;
      out_ovf  <= 1'b0;
      out_unf  <= 1'b0;
      out_nan  <= 1'b0;
    end else if (rdy_p2) begin
      vld_p2 <= vld_p1;
      if (vld_p1) begin
        out_data <= res_c;
        out_ovf  <= ovf_c;
        out_unf  <= unf_c;
        out_nan  <= nan_c;
      end
    end
  end

endmodule

// File: tb/tb_float_to_fixed_pipe.sv
// Scoreboard bench for float_to_fixed_pipe (default OUT_W=32, FRAC_BITS=30).
// Expected results are pushed at input acceptance; a monitor pops and
// compares on every output transfer and checks output stability under stall.
module tb_float_to_fixed_pipe;

  localparam int OUT_W = 32;
  localparam int NV    = 17;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [31:0]      in_data = '0;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_data;
  logic             out_ovf, out_unf, out_nan;

  float_to_fixed_pipe #(.OUT_W(OUT_W), .FRAC_BITS(30)) dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_ovf(out_ovf), .out_unf(out_unf), .out_nan(out_nan)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] d;
    logic [2:0]  flg;   // {nan, unf, ovf}
    int          acc;
    bit          lat;
    int          idx;
  } exp_t;
  exp_t sbq[$];

  logic [31:0] vin  [NV];
  logic [31:0] vout [NV];
  logic [2:0]  vflg [NV];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // out_ready driver: 0 = held high, 1 = held low, 2 = pseudo-random
  int          orm = 0;
  logic [15:0] lfsr = 16'hACE1;
  always @(negedge clk) begin
    #1;
    lfsr = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    case (orm)
      0:       out_ready = 1'b1;
      1:       out_ready = 1'b0;
      default: out_ready = lfsr[0];
    endcase
  end

  // Monitor
  bit          held = 0;
  logic [34:0] held_val;
  always @(negedge clk) begin
    exp_t e;
    #2;
    if (reset_n && out_valid) begin
      if (held)
        chk("stall_stable", {out_nan, out_unf, out_ovf, out_data}, held_val);
      if (out_ready) begin
        held = 0;
        if (sbq.size() == 0) begin
          chk("unexpected_out", {out_nan, out_unf, out_ovf, out_data}, 64'hDEAD);
        end else begin
          e = sbq.pop_front();
          chk($sformatf("data[%0d]", e.idx), out_data, e.d);
          chk($sformatf("flags[%0d]", e.idx), {out_nan, out_unf, out_ovf}, e.flg);
          if (e.lat) chk($sformatf("latency[%0d]", e.idx), 64'(cyc - e.acc), 64'd3);
        end
      end else begin
        held = 1;
        held_val = {out_nan, out_unf, out_ovf, out_data};
      end
    end else begin
      held = 0;
    end
  end

  task automatic send(input int i, input bit push, input bit lat);
    exp_t e;
    int n;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = vin[i];
    #2;
    n = 0;
    while (!in_ready && n < 500) begin
      @(negedge clk);
      #2;
      n++;
    end
    if (!in_ready) begin
      chk("in_ready_timeout", 0, 1);
      in_valid = 1'b0;
    end else begin
      @(posedge clk);
      if (push) begin
        e.d = vout[i]; e.flg = vflg[i]; e.acc = cyc; e.lat = lat; e.idx = i;
        sbq.push_back(e);
      end
    end
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sbq.size() > 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    repeat (5) @(negedge clk);
    chk("drain_empty", 64'(sbq.size()), 64'd0);
  endtask

  initial begin
    vin[0]  = 32'h3f800000; vout[0]  = 32'h40000000; vflg[0]  = 3'b000;
    vin[1]  = 32'hbf800000; vout[1]  = 32'hC0000000; vflg[1]  = 3'b000;
    vin[2]  = 32'h30800000; vout[2]  = 32'h00000001; vflg[2]  = 3'b000;
`ifdef ROUND_NEAREST_EN
    vin[3]  = 32'h350637bd; vout[3]  = 32'h00000219; vflg[3]  = 3'b000;
`else
    vin[3]  = 32'h350637bd; vout[3]  = 32'h00000218; vflg[3]  = 3'b000;
`endif
    vin[4]  = 32'h3f47ae14; vout[4]  = 32'h31EB8500; vflg[4]  = 3'b000;
    vin[5]  = 32'h40000000; vout[5]  = 32'h7FFFFFFF; vflg[5]  = 3'b001;
    vin[6]  = 32'hC0000000; vout[6]  = 32'h80000000; vflg[6]  = 3'b000;
    vin[7]  = 32'h7f800000; vout[7]  = 32'h7FFFFFFF; vflg[7]  = 3'b001;
    vin[8]  = 32'h7fc00000; vout[8]  = 32'h00000000; vflg[8]  = 3'b100;
    vin[9]  = 32'h00000001; vout[9]  = 32'h00000000; vflg[9]  = 3'b010;
    vin[10] = 32'h2f800000; vout[10] = 32'h00000000; vflg[10] = 3'b010;
    vin[11] = 32'h80000000; vout[11] = 32'h00000000; vflg[11] = 3'b000;
    vin[12] = 32'hff800000; vout[12] = 32'h80000000; vflg[12] = 3'b001;
    vin[13] = 32'h3f000000; vout[13] = 32'h20000000; vflg[13] = 3'b000;
    vin[14] = 32'hbec00000; vout[14] = 32'hE8000000; vflg[14] = 3'b000;
    vin[15] = 32'hc0400000; vout[15] = 32'h80000000; vflg[15] = 3'b001;
    vin[16] = 32'hbfffffff; vout[16] = 32'h80000080; vflg[16] = 3'b000;

    // Reset state
    orm = 0;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    #2;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_flags", {out_nan, out_unf, out_ovf}, 0);
    chk("rst_in_ready", in_ready, 1);
    @(negedge clk);
    reset_n = 1'b1;

    // Continuous flow through every vector, exact latency
    for (int i = 0; i < NV; i++) send(i, 1'b1, 1'b1);
    idle();
    drain();

    // Fill under stall, then stream with random backpressure
    orm = 1;
    @(negedge clk);
    send(0, 1'b1, 1'b0);
    send(1, 1'b1, 1'b0);
    send(2, 1'b1, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    #2;
    chk("full_in_ready", in_ready, 0);
    chk("full_out_valid", out_valid, 1);
    repeat (3) @(negedge clk);
    orm = 2;
    send(3, 1'b1, 1'b0);
    send(4, 1'b1, 1'b0);
    send(5, 1'b1, 1'b0);
    send(12, 1'b1, 1'b0);
    send(14, 1'b1, 1'b0);
    idle();
    drain();

    // Reset with three words in flight
    orm = 1;
    @(negedge clk);
    send(8, 1'b0, 1'b0);
    send(9, 1'b0, 1'b0);
    send(10, 1'b0, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    reset_n = 1'b0;
    @(negedge clk);
    #2;
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_out_data", out_data, 0);
    chk("mid_rst_flags", {out_nan, out_unf, out_ovf}, 0);
    chk("mid_rst_in_ready", in_ready, 1);
    reset_n = 1'b1;
    orm = 0;
    send(13, 1'b1, 1'b1);
    send(15, 1'b1, 1'b1);
    idle();
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
